// File: rtl/ddr3_init_seq_pkg.sv
// Shared definitions for the DDR3 power-up / initialization sequencer:
// state encoding, command pin encodings, default timings and sizing helpers.
package ddr3_mem_pkg;

  // Sequencer states, in the order the power-up sequence walks them.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RST_HOLD = 4'd1,
    ST_CKE_WAIT = 4'd2,
    ST_XPR_WAIT = 4'd3,
    ST_MRS2     = 4'd4,
    ST_MRS3     = 4'd5,
    ST_MRS1     = 4'd6,
    ST_MRS0     = 4'd7,
    ST_ZQCL     = 4'd8,
    ST_DONE     = 4'd9
  } state_e;

  // Command pin encodings {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_DES  = 4'b1111;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;

  // ZQCL is a ZQ calibration with A10 high (long calibration).
  localparam logic [14:0] ZQCL_ADDR = 15'h0400;

  // Default timings in controller clock cycles.
  localparam int DEF_T_RST    = 200;
  localparam int DEF_T_CKE    = 500;
  localparam int DEF_T_XPR    = 5;
  localparam int DEF_T_MRD    = 4;
  localparam int DEF_T_MOD    = 12;
  localparam int DEF_T_ZQINIT = 512;

  // Larger of two integers, used to size the shared delay counter.
  function automatic int max_of(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Counter width able to hold (maxv - 1); never narrower than one bit.
  function automatic int cnt_width(input int maxv);
    int w;
    w = $clog2(maxv);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/ddr3_init_seq_if.sv
// Control handshake and DDR3 command pins between the init sequencer
// (master) and the controller / memory side (slave).
interface ddr3_init_seq_if;
  import ddr3_mem_pkg::*;

  logic        start;
  logic        mem_reset_n;
  logic        cke;
  logic [3:0]  cmd;
  logic [2:0]  ba;
  logic [14:0] addr;
  logic        busy;
  logic        init_done;

  modport master (
    input  start,
    output mem_reset_n, cke, cmd, ba, addr, busy, init_done
  );

  modport slave (
    output start,
    input  mem_reset_n, cke, cmd, ba, addr, busy, init_done
  );

endinterface

// File: rtl/ddr3_delay_cnt.sv
// Loadable down-counter that times each sequencer state. It stops at zero
// and reports both its value and a zero flag.
module ddr3_delay_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load on state entry, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up and initialization sequencer. Walks RESET# hold, CKE wait,
// tXPR, MR2/MR3/MR1/MR0 programming and ZQCL, then raises init_done.
// All pin outputs are registered from the next-state decode so each state's
// pin values appear on its first cycle with no path from start to a pin.
module ddr3_init_seq
  import ddr3_mem_pkg::*;
#(
  parameter int          T_RST    = DEF_T_RST,
  parameter int          T_CKE    = DEF_T_CKE,
  parameter int          T_XPR    = DEF_T_XPR,
  parameter int          T_MRD    = DEF_T_MRD,
  parameter int          T_MOD    = DEF_T_MOD,
  parameter int          T_ZQINIT = DEF_T_ZQINIT,
  parameter logic [14:0] MR0_VAL  = 15'h0000,
  parameter logic [14:0] MR1_VAL  = 15'h0000,
  parameter logic [14:0] MR2_VAL  = 15'h0000,
  parameter logic [14:0] MR3_VAL  = 15'h0000
) (
  input  logic               cpu_clk,
  input  logic               RESET,
  ddr3_init_seq_if.master    bus
);

  localparam int T_MAX = max_of(max_of(max_of(T_RST, T_CKE), max_of(T_XPR, T_MRD)),
                                max_of(T_MOD, T_ZQINIT));
  localparam int CW    = cnt_width(T_MAX);

  state_e      r_state;
  state_e      w_next;
  logic        w_load;
  logic [CW-1:0] w_load_val;
  logic [CW-1:0] w_cnt;
  logic        w_zero;
  logic        w_expire;

  logic        w_mem_reset_n;
  logic        w_cke;
  logic [3:0]  w_cmd;
  logic [2:0]  w_ba;
  logic [14:0] w_addr;
  logic        w_busy;
  logic        w_done;

  logic        r_mem_reset_n;
  logic        r_cke;
  logic [3:0]  r_cmd;
  logic [2:0]  r_ba;
  logic [14:0] r_addr;
  logic        r_busy;
  logic        r_done;

  // Counter preload for a state: its duration minus one.
  function automatic logic [CW-1:0] dur_of(input state_e s);
    case (s)
      ST_RST_HOLD: return CW'(T_RST - 1);
      ST_CKE_WAIT: return CW'(T_CKE - 1);
      ST_XPR_WAIT: return CW'(T_XPR - 1);
      ST_MRS2:     return CW'(T_MRD - 1);
      ST_MRS3:     return CW'(T_MRD - 1);
      ST_MRS1:     return CW'(T_MRD - 1);
      ST_MRS0:     return CW'(T_MOD - 1);
      ST_ZQCL:     return CW'(T_ZQINIT - 1);
      default:     return '0;
    endcase
  endfunction

  ddr3_delay_cnt #(
    .W (CW)
  ) u_delay_cnt (
    .clk        (cpu_clk),
    .rst        (RESET),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_value    (w_cnt),
    .o_zero     (w_zero)
  );

  // Flag and value must agree before a timed window may close, so a single
  // corrupted flag cannot shorten a memory timing.
  assign w_expire = w_zero && (w_cnt == '0);

  // State register.
  always_ff @(posedge cpu_clk or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and counter preload on every state change.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) w_next = ST_RST_HOLD;
        else           w_next = r_state;
      end
      ST_RST_HOLD: begin
        if (w_expire) w_next = ST_CKE_WAIT;
        else          w_next = r_state;
      end
      ST_CKE_WAIT: begin
        if (w_expire) w_next = ST_XPR_WAIT;
        else          w_next = r_state;
      end
      ST_XPR_WAIT: begin
        if (w_expire) w_next = ST_MRS2;
        else          w_next = r_state;
      end
      ST_MRS2: begin
        if (w_expire) w_next = ST_MRS3;
        else          w_next = r_state;
      end
      ST_MRS3: begin
        if (w_expire) w_next = ST_MRS1;
        else          w_next = r_state;
      end
      ST_MRS1: begin
        if (w_expire) w_next = ST_MRS0;
        else          w_next = r_state;
      end
      ST_MRS0: begin
        if (w_expire) w_next = ST_ZQCL;
        else          w_next = r_state;
      end
      ST_ZQCL: begin
        if (w_expire) w_next = ST_DONE;
        else          w_next = r_state;
      end
      default: w_next = ST_IDLE;
    endcase
    w_load     = (w_next != r_state);
    w_load_val = dur_of(w_next);
  end

  // Pin values for the state being entered; commands only on its first cycle.
  always_comb begin
    w_mem_reset_n = 1'b1;
    w_cke         = 1'b1;
    w_cmd         = CMD_NOP;
    w_ba          = 3'd0;
    w_addr        = 15'd0;
    w_busy        = 1'b1;
    w_done        = 1'b0;
    case (w_next)
      ST_IDLE: begin
        w_mem_reset_n = 1'b0;
        w_cke         = 1'b0;
        w_cmd         = CMD_DES;
        w_busy        = 1'b0;
      end
      ST_RST_HOLD: begin
        w_mem_reset_n = 1'b0;
        w_cke         = 1'b0;
      end
      ST_CKE_WAIT: begin
        w_cke = 1'b0;
      end
      ST_XPR_WAIT: begin
        w_cmd = CMD_NOP;
      end
      ST_MRS2: begin
        if (w_load) begin
          w_cmd = CMD_MRS; w_ba = 3'd2; w_addr = MR2_VAL;
        end else begin
          w_cmd = CMD_NOP;
        end
      end
      ST_MRS3: begin
        if (w_load) begin
          w_cmd = CMD_MRS; w_ba = 3'd3; w_addr = MR3_VAL;
        end else begin
          w_cmd = CMD_NOP;
        end
      end
      ST_MRS1: begin
        if (w_load) begin
          w_cmd = CMD_MRS; w_ba = 3'd1; w_addr = MR1_VAL;
        end else begin
          w_cmd = CMD_NOP;
        end
      end
      ST_MRS0: begin
        if (w_load) begin
          w_cmd = CMD_MRS; w_ba = 3'd0; w_addr = MR0_VAL;
        end else begin
          w_cmd = CMD_NOP;
        end
      end
      ST_ZQCL: begin
        if (w_load) begin
          w_cmd = CMD_ZQCL; w_addr = ZQCL_ADDR;
        end else begin
          w_cmd = CMD_NOP;
        end
      end
      ST_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
      end
      default: begin
        w_mem_reset_n = 1'b0;
        w_cke         = 1'b0;
        w_cmd         = CMD_DES;
        w_busy        = 1'b0;
      end
    endcase
  end

  // Output registers; reset parks the pins in the safe deselected state.
  always_ff @(posedge cpu_clk or posedge RESET) begin
    if (RESET) begin
      r_mem_reset_n <= 1'b0;
      r_cke         <= 1'b0;
      r_cmd         <= CMD_DES;
      r_ba          <= 3'd0;
      r_addr        <= 15'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_mem_reset_n <= w_mem_reset_n;
      r_cke         <= w_cke;
      r_cmd         <= w_cmd;
      r_ba          <= w_ba;
      r_addr        <= w_addr;
      r_busy        <= w_busy;
      r_done        <= w_done;
    end
  end

  assign bus.mem_reset_n = r_mem_reset_n;
  assign bus.cke         = r_cke;
  assign bus.cmd         = r_cmd;
  assign bus.ba          = r_ba;
  assign bus.addr        = r_addr;
  assign bus.busy        = r_busy;
  assign bus.init_done   = r_done;

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Self-checking bench for ddr3_init_seq. Expected pins come from a segment
// model: the sequence is a list of state durations, and the pin values for
// cycle k after start are found by walking that list.
module tb_ddr3_init_seq;

  localparam int P_RST = 4, P_CKE = 5, P_XPR = 3, P_MRD = 4, P_MOD = 12, P_ZQ = 8;
  localparam logic [14:0] V0 = 15'h0001, V1 = 15'h0101, V2 = 15'h0201, V3 = 15'h0301;

  typedef struct packed {
    logic        rn;
    logic        ck;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [14:0] addr;
    logic        busy;
    logic        done;
  } obs_t;

  logic cpu_clk = 1'b0;
  logic RESET;
  int   vecs = 0;
  int   errs = 0;

  always #5 cpu_clk = ~cpu_clk;

  ddr3_init_seq_if ifa ();
  ddr3_init_seq_if ifb ();

  ddr3_init_seq #(
    .T_RST(P_RST), .T_CKE(P_CKE), .T_XPR(P_XPR), .T_MRD(P_MRD), .T_MOD(P_MOD),
    .T_ZQINIT(P_ZQ), .MR0_VAL(V0), .MR1_VAL(V1), .MR2_VAL(V2), .MR3_VAL(V3)
  ) dut_a (
    .cpu_clk (cpu_clk),
    .RESET   (RESET),
    .bus     (ifa)
  );

  ddr3_init_seq #(
    .T_RST(1), .T_CKE(1), .T_XPR(1), .T_MRD(1), .T_MOD(1),
    .T_ZQINIT(1), .MR0_VAL(V0), .MR1_VAL(V1), .MR2_VAL(V2), .MR3_VAL(V3)
  ) dut_b (
    .cpu_clk (cpu_clk),
    .RESET   (RESET),
    .bus     (ifb)
  );

  function automatic obs_t idle_obs();
    return {1'b0, 1'b0, 4'b1111, 3'd0, 15'd0, 1'b0, 1'b0};
  endfunction

  function automatic obs_t get_obs(input bit sel);
    if (sel)
      return {ifb.mem_reset_n, ifb.cke, ifb.cmd, ifb.ba, ifb.addr, ifb.busy, ifb.init_done};
    else
      return {ifa.mem_reset_n, ifa.cke, ifa.cmd, ifa.ba, ifa.addr, ifa.busy, ifa.init_done};
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) ifb.start = v;
    else     ifa.start = v;
  endtask

  // Reference: pins in cycle k (k>=1) after the start pulse sampled in cycle 0.
  function automatic obs_t exp_obs(input bit sel, input int k);
    int   dur[8];
    int   t;
    obs_t o;
    if (sel) dur = '{1, 1, 1, 1, 1, 1, 1, 1};
    else     dur = '{P_RST, P_CKE, P_XPR, P_MRD, P_MRD, P_MRD, P_MOD, P_ZQ};
    o = {1'b1, 1'b1, 4'b0111, 3'd0, 15'd0, 1'b0, 1'b1};
    t = k - 1;
    for (int i = 0; i < 8; i++) begin
      if (t >= 0 && t < dur[i]) begin
        o.rn = (i >= 1); o.ck = (i >= 2);
        o.cmd = 4'b0111; o.ba = 3'd0; o.addr = 15'd0;
        o.busy = 1'b1; o.done = 1'b0;
        if (t == 0) begin
          case (i)
            3: begin o.cmd = 4'b0000; o.ba = 3'd2; o.addr = V2; end
            4: begin o.cmd = 4'b0000; o.ba = 3'd3; o.addr = V3; end
            5: begin o.cmd = 4'b0000; o.ba = 3'd1; o.addr = V1; end
            6: begin o.cmd = 4'b0000; o.ba = 3'd0; o.addr = V0; end
            7: begin o.cmd = 4'b0110; o.addr = 15'h0400; end
            default: ;
          endcase
        end
      end
      t -= dur[i];
    end
    return o;
  endfunction

  // Pulse start, then check every cycle through DONE; optionally toss in
  // start pulses while busy, which must be ignored.
  task automatic run_init(input bit sel, input bit extras, input string tag);
    int   sum;
    obs_t e, o;
    sum = sel ? 8 : 44;
    @(negedge cpu_clk);
    set_start(sel, 1'b1);
    for (int k = 1; k <= sum + 3; k++) begin
      @(negedge cpu_clk);
      if (extras && k <= sum && (k == 3 || k == 30 || $urandom_range(0, 4) == 0))
        set_start(sel, 1'b1);
      else
        set_start(sel, 1'b0);
      e = exp_obs(sel, k);
      o = get_obs(sel);
      vecs++;
      if (o !== e) begin
        errs++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, k, o, e);
      end
    end
    set_start(sel, 1'b0);
  endtask

  task automatic test_reset();
    int n;
    RESET = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (3) @(negedge cpu_clk);
    for (int s = 0; s < 2; s++) begin
      vecs++;
      if (get_obs(s[0]) !== idle_obs()) begin
        errs++;
        $display("FAIL reset_%0d: got %h expected %h", s, get_obs(s[0]), idle_obs());
      end
    end
    RESET = 1'b0;
    n = $urandom_range(5, 20);
    for (int k = 0; k < n; k++) begin
      @(negedge cpu_clk);
      vecs++;
      if (get_obs(1'b0) !== idle_obs()) begin
        errs++;
        $display("FAIL idle_wait cycle %0d: got %h expected %h", k, get_obs(1'b0), idle_obs());
      end
    end
  endtask

  task automatic test_reset_mid();
    int   r;
    obs_t e, o;
    for (int pass = 0; pass < 2; pass++) begin
      r = (pass == 0) ? 20 : $urandom_range(13, 40);
      @(negedge cpu_clk);
      ifa.start = 1'b1;
      for (int k = 1; k <= r; k++) begin
        @(negedge cpu_clk);
        ifa.start = 1'b0;
        e = exp_obs(1'b0, k);
        o = get_obs(1'b0);
        vecs++;
        if (o !== e) begin
          errs++;
          $display("FAIL pre_reset cycle %0d: got %h expected %h", k, o, e);
        end
      end
      #1 RESET = 1'b1;
      #1;
      vecs++;
      if (get_obs(1'b0) !== idle_obs()) begin
        errs++;
        $display("FAIL async_reset at %0d: got %h expected %h", r, get_obs(1'b0), idle_obs());
      end
      repeat (2) @(negedge cpu_clk);
      RESET = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge cpu_clk);
        vecs++;
        if (get_obs(1'b0) !== idle_obs()) begin
          errs++;
          $display("FAIL post_reset_idle cycle %0d: got %h expected %h", k, get_obs(1'b0), idle_obs());
        end
      end
      run_init(1'b0, 1'b0, "after_reset");
    end
  endtask

  task automatic test_basic();           run_init(1'b0, 1'b0, "basic");        endtask
  task automatic test_restart_from_done(); run_init(1'b0, 1'b0, "restart");    endtask
  task automatic test_ignored_starts();  run_init(1'b0, 1'b1, "extra_start");  endtask
  task automatic test_all_ones();
    run_init(1'b1, 1'b0, "ones");
    run_init(1'b1, 1'b1, "ones_extra");
  endtask

  initial begin
    RESET = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    test_reset();
    test_basic();
    test_restart_from_done();
    test_ignored_starts();
    test_reset_mid();
    test_all_ones();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ddr3_init_seq.md
DDR3_INIT_SEQ -- requirements
Module: ddr3_init_seq

Purpose: drives the JEDEC DDR3 power-up and initialization sequence onto the memory command pins. It runs under the memory controller and hands over when init_done is asserted.

Interface
Parameters (name, default, meaning):
REQ-001 T_RST, 200, cycles mem_reset_n held low; minimum 1.
REQ-002 T_CKE, 500, cycles cke held low after reset release; minimum 1.
REQ-003 T_XPR, 5, NOP cycles with cke high before the first MRS; minimum 1.
REQ-004 T_MRD, 4, total cycles of each MR2/MR3/MR1 step, including its command cycle; minimum 1.
REQ-005 T_MOD, 12, total cycles of the MR0 step; minimum 1.
REQ-006 T_ZQINIT, 512, total cycles of the ZQCL step; minimum 1.
REQ-007 MR0_VAL/MR1_VAL/MR2_VAL/MR3_VAL, 15'h0000 each, address-bus payload for each mode register.
Ports (name, direction, width, meaning):
REQ-008 cpu_clk, in, 1, sole clock; all logic is on the rising edge.
REQ-009 RESET, in, 1, asynchronous active-high reset.
REQ-010 start, in, 1, one-cycle request to begin or re-run initialization.
REQ-011 mem_reset_n, out, 1, DDR3 RESET# pin.
REQ-012 cke, out, 1, DDR3 clock enable.
REQ-013 cmd, out, 4, {cs_n,ras_n,cas_n,we_n}.
REQ-014 ba, out, 3, bank address.
REQ-015 addr, out, 15, row/mode address.
REQ-016 busy, out, 1, high in every state except IDLE and DONE.
REQ-017 init_done, out, 1, high only in DONE.

Function
REQ-018 States: IDLE, RST_HOLD, CKE_WAIT, XPR_WAIT, MRS2, MRS3, MRS1, MRS0, ZQCL, DONE.
REQ-019 State duration: each timed state lasts exactly its parameter in cycles, using a down-counter loaded with N-1 on entry; the state exits on the cycle where the count is 0.
REQ-020 Timed states: RST_HOLD uses T_RST, CKE_WAIT uses T_CKE, XPR_WAIT uses T_XPR, MRS2/MRS3/MRS1 use T_MRD, MRS0 uses T_MOD, ZQCL uses T_ZQINIT.
REQ-021 Transition order: RST_HOLD, CKE_WAIT, XPR_WAIT, MRS2, MRS3, MRS1, MRS0, ZQCL, DONE.
REQ-022 Start from IDLE or DONE: start sampled high moves to RST_HOLD on the next cycle, and init_done drops that cycle.
REQ-023 start asserted in any busy state is ignored; there is no queuing.
REQ-024 mem_reset_n is 0 in IDLE and RST_HOLD, and 1 in all other states.
REQ-025 cke is 0 in IDLE, RST_HOLD and CKE_WAIT, and 1 in all other states.
REQ-026 MRS command: on the first cycle of MRSn, cmd=4'b0000, ba=n, addr=MRn_VAL.
REQ-027 ZQCL command: on the first cycle of ZQCL, cmd=4'b0110, ba=0, addr[10]=1, all other addr bits 0.
REQ-028 Other cycles: cmd=NOP 4'b0111 with ba=0 and addr=0, except in IDLE where cmd=deselect 4'b1111.
REQ-029 All outputs are registered; none is combinational from start.

Reset
REQ-030 RESET asserted at any time, including mid-sequence, immediately forces: state=IDLE, counter=0, mem_reset_n=0, cke=0, cmd=4'b1111, ba=0, addr=0, busy=0, init_done=0.
REQ-031 After RESET is deasserted the block waits in IDLE for start; it does not auto-start.

Structure
REQ-032 The shared package ddr3_mem_pkg holds:
- the state enum;
- command encodings CMD_DES, CMD_NOP, CMD_MRS, CMD_ZQCL;
- default timing constants.
REQ-033 The block contains one sub-module, ddr3_delay_cnt: a loadable down-counter with load, value, and zero-flag outputs, sized by $clog2 of the largest timing parameter.

Verification
All scenarios use parameters T_RST=4, T_CKE=5, T_XPR=3, T_MRD=4, T_MOD=12, T_ZQINIT=8, and MRn_VAL=15'h0n01.
REQ-034 Start pulse at cycle 0 -> mem_reset_n low for cycles 1-4 and high from cycle 5; cke high from cycle 10; MRS with ba=2 and addr=15'h0201 at cycle 13; MRS ba=3 at 17; MRS ba=1 at 21; MRS ba=0 at 25; ZQCL at 37; init_done=1 from cycle 45.
REQ-035 Extra start pulses at cycles 3 and 30 -> trace identical to REQ-034.
REQ-036 RESET asserted at cycle 20 -> outputs take reset values at once; no MRS is ever issued afterward; after RESET drops the block stays in IDLE until start.
REQ-037 Start in DONE -> init_done=0 and mem_reset_n=0 on the next cycle; the full REQ-034 sequence then repeats.
REQ-038 All parameters set to 1 -> each state lasts one cycle; init_done asserts 9 cycles after start; every command sits on the first cycle of its state.
